// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS forwarding/hazard logic.
package mips_pkg;

    // Operand mux select encodings (11 is never driven)
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;

    // Widest register address the shadow slots can hold; narrower
    // addresses are zero-extended on entry so comparisons stay exact.
    localparam int MAX_REG_W = 8;
    typedef logic [MAX_REG_W-1:0] reg_addr_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } fhu_state_t;

    // Producer view of the instruction in EX. Source registers are
    // compared while the consumer is still in ID, so they are not kept.
    typedef struct packed {
        logic      valid;
        reg_addr_t dest;
        logic      regwrite;
        logic      memread;
    } ex_slot_t;

    // Producer view of the instruction in MEM.
    typedef struct packed {
        logic      valid;
        reg_addr_t dest;
        logic      regwrite;
    } mem_slot_t;

endpackage

// File: rtl/fwd_select.sv
// Match and priority for one ALU operand: the newest producer wins.
module fwd_select
    import mips_pkg::*;
(
    input  logic       i_Ex_Valid,
    input  logic       i_Ex_RegWrite,
    input  reg_addr_t  i_Ex_Dest,
    input  logic       i_Mem_Valid,
    input  logic       i_Mem_RegWrite,
    input  reg_addr_t  i_Mem_Dest,
    input  reg_addr_t  i_Src,
    output logic [1:0] o_Sel
);

    logic w_ex_match;
    logic w_mem_match;

    // A slot matches when it writes a non-zero register equal to the source
    always_comb begin
        w_ex_match  = i_Ex_Valid  & i_Ex_RegWrite  & (i_Ex_Dest  != '0) & (i_Ex_Dest  == i_Src);
        w_mem_match = i_Mem_Valid & i_Mem_RegWrite & (i_Mem_Dest != '0) & (i_Mem_Dest == i_Src);
    end

    // EX/MEM result has priority over MEM/WB result
    always_comb begin
        o_Sel = FWD_REGFILE;
        if (w_ex_match)
            o_Sel = FWD_EXMEM;
        else if (w_mem_match)
            o_Sel = FWD_MEMWB;
    end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Forwarding select and load-use stall controller beside the ID/EX register.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | normal flow; a load-use hazard stalls and moves to STALL
// STALL | EX holds the bubble; returns to RUN on the next enabled edge
//
// The writeback stage is not tracked: write-before-read for the WB
// instruction is resolved inside the register file.
module forwarding_hazard_unit
    import mips_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset_n,
    input  logic                      i_Enable,
    input  logic                      i_Flush,
    input  logic                      i_Dec_Valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_Dec_Rs,
    input  logic [REG_ADDR_WIDTH-1:0] i_Dec_Rt,
    input  logic [REG_ADDR_WIDTH-1:0] i_Dec_Dest,
    input  logic                      i_Dec_RegWrite,
    input  logic                      i_Dec_MemRead,
    output logic [1:0]                o_Fwd_A,
    output logic [1:0]                o_Fwd_B,
    output logic                      o_Stall,
    output logic [COUNT_WIDTH-1:0]    o_Stall_Count
);

    fhu_state_t             r_state;
    fhu_state_t             w_state_nxt;
    ex_slot_t               r_ex;
    ex_slot_t               w_ex_nxt;
    mem_slot_t              r_mem;
    mem_slot_t              w_mem_nxt;
    logic [1:0]             r_fwd_a;
    logic [1:0]             r_fwd_b;
    logic [1:0]             w_fwd_a_nxt;
    logic [1:0]             w_fwd_b_nxt;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] w_count_nxt;

    reg_addr_t w_rs;
    reg_addr_t w_rt;
    reg_addr_t w_dest;
    logic      w_hazard;
    logic      w_bubble;
    logic [1:0] w_sel_a;
    logic [1:0] w_sel_b;

    // Zero-extend ID addresses into the slot width
    always_comb begin
        w_rs   = reg_addr_t'(i_Dec_Rs);
        w_rt   = reg_addr_t'(i_Dec_Rt);
        w_dest = reg_addr_t'(i_Dec_Dest);
    end

    // Load in EX feeding the instruction in ID; flush overrides the stall
    always_comb begin
        w_hazard = r_ex.valid & r_ex.memread & (r_ex.dest != '0) & i_Dec_Valid
                 & ((r_ex.dest == w_rs) | (r_ex.dest == w_rt));
        o_Stall  = w_hazard & ~i_Flush;
        w_bubble = i_Flush | o_Stall;
    end

    fwd_select u_fwd_a (
        .i_Ex_Valid     (r_ex.valid),
        .i_Ex_RegWrite  (r_ex.regwrite),
        .i_Ex_Dest      (r_ex.dest),
        .i_Mem_Valid    (r_mem.valid),
        .i_Mem_RegWrite (r_mem.regwrite),
        .i_Mem_Dest     (r_mem.dest),
        .i_Src          (w_rs),
        .o_Sel          (w_sel_a)
    );

    fwd_select u_fwd_b (
        .i_Ex_Valid     (r_ex.valid),
        .i_Ex_RegWrite  (r_ex.regwrite),
        .i_Ex_Dest      (r_ex.dest),
        .i_Mem_Valid    (r_mem.valid),
        .i_Mem_RegWrite (r_mem.regwrite),
        .i_Mem_Dest     (r_mem.dest),
        .i_Src          (w_rt),
        .o_Sel          (w_sel_b)
    );

    // Next-state for FSM, shadow slots, selects and stall counter
    always_comb begin
        w_state_nxt = r_state;
        w_ex_nxt    = r_ex;
        w_mem_nxt   = r_mem;
        w_fwd_a_nxt = r_fwd_a;
        w_fwd_b_nxt = r_fwd_b;
        w_count_nxt = r_count;

        if (i_Enable) begin
            w_mem_nxt.valid    = r_ex.valid;
            w_mem_nxt.dest     = r_ex.dest;
            w_mem_nxt.regwrite = r_ex.regwrite;

            if (w_bubble) begin
                w_ex_nxt    = '0;
                w_fwd_a_nxt = FWD_REGFILE;
                w_fwd_b_nxt = FWD_REGFILE;
            end else begin
                w_ex_nxt.valid    = i_Dec_Valid;
                w_ex_nxt.dest     = w_dest;
                w_ex_nxt.regwrite = i_Dec_RegWrite;
                w_ex_nxt.memread  = i_Dec_MemRead;
                w_fwd_a_nxt       = w_sel_a;
                w_fwd_b_nxt       = w_sel_b;
            end

            if (o_Stall && (r_count != '1))
                w_count_nxt = r_count + COUNT_WIDTH'(1);

            case (r_state)
                ST_RUN:   w_state_nxt = o_Stall ? ST_STALL : ST_RUN;
                ST_STALL: w_state_nxt = ST_RUN;
                default:  w_state_nxt = ST_RUN;
            endcase
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state <= ST_RUN;
            r_ex    <= '0;
            r_mem   <= '0;
            r_fwd_a <= FWD_REGFILE;
            r_fwd_b <= FWD_REGFILE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ex    <= w_ex_nxt;
            r_mem   <= w_mem_nxt;
            r_fwd_a <= w_fwd_a_nxt;
            r_fwd_b <= w_fwd_b_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign o_Fwd_A       = r_fwd_a;
    assign o_Fwd_B       = r_fwd_b;
    assign o_Stall_Count = r_count;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Scoreboard bench for forwarding_hazard_unit: directed MIPS sequences
// followed by random traffic, checked against an instruction-history model.
module tb_forwarding_hazard_unit;

    localparam int AW = 5;
    localparam int CW = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b1;
    logic          flush = 1'b0;
    logic          dv = 1'b0;
    logic [AW-1:0] rs = '0;
    logic [AW-1:0] rt = '0;
    logic [AW-1:0] dst = '0;
    logic          drw = 1'b0;
    logic          dmr = 1'b0;
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic          stall;
    logic [CW-1:0] cnt;

    always #5 clk = ~clk;

    forwarding_hazard_unit #(.REG_ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .i_Clock        (clk),
        .i_Reset_n      (rst_n),
        .i_Enable       (en),
        .i_Flush        (flush),
        .i_Dec_Valid    (dv),
        .i_Dec_Rs       (rs),
        .i_Dec_Rt       (rt),
        .i_Dec_Dest     (dst),
        .i_Dec_RegWrite (drw),
        .i_Dec_MemRead  (dmr),
        .o_Fwd_A        (fa),
        .o_Fwd_B        (fb),
        .o_Stall        (stall),
        .o_Stall_Count  (cnt)
    );

    // Instructions that entered EX, newest first (bubbles are invalid entries)
    typedef struct {
        bit valid;
        int dest;
        bit rw;
        bit mr;
    } instr_t;

    typedef struct {
        int    fa;
        int    fb;
        int    stall;
        int    cnt;
        string tag;
    } exp_t;

    instr_t hist[$];
    exp_t   sbq[$];
    int     m_fa = 0;
    int     m_fb = 0;
    int     m_cnt = 0;
    int     n_cmp = 0;
    int     n_bad = 0;

    function automatic bit writes(int age, int r);
        if (hist.size() <= age) return 1'b0;
        return hist[age].valid && hist[age].rw && hist[age].dest != 0 && hist[age].dest == r;
    endfunction

    function automatic int sel_for(int r);
        if (writes(0, r)) return 2;
        if (writes(1, r)) return 1;
        return 0;
    endfunction

    function automatic bit model_stall(bit v, int s, int t, bit fl);
        if (fl || !v || hist.size() == 0) return 1'b0;
        return hist[0].valid && hist[0].mr && hist[0].dest != 0 &&
               (hist[0].dest == s || hist[0].dest == t);
    endfunction

    // One pipeline cycle: drive ID, record expectations, advance the model
    task automatic step(input string tag, input bit v, input int s, input int t, input int d,
                        input bit w, input bit m, input bit fl, input bit e);
        exp_t   x;
        instr_t ni;
        bit     st;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en    = e;
        flush = fl;
        dv    = v;
        rs    = AW'(s);
        rt    = AW'(t);
        dst   = AW'(d);
        drw   = w;
        dmr   = m;
        st = model_stall(v, s, t, fl);
        x.fa = m_fa; x.fb = m_fb; x.stall = int'(st); x.cnt = m_cnt; x.tag = tag;
        sbq.push_back(x);
        if (e) begin
            if (fl || st) begin
                m_fa = 0; m_fb = 0;
                ni.valid = 1'b0; ni.dest = 0; ni.rw = 1'b0; ni.mr = 1'b0;
            end else begin
                m_fa = sel_for(s); m_fb = sel_for(t);
                ni.valid = v; ni.dest = d; ni.rw = w; ni.mr = m;
            end
            hist.push_front(ni);
            if (hist.size() > 2) void'(hist.pop_back());
            if (st && m_cnt < CMAX) m_cnt++;
        end
    endtask

    // Assert reset mid-cycle with the given ID inputs; outputs must clear at once
    task automatic reset_step(input string tag, input bit v, input int s, input int t, input int d,
                              input bit w, input bit m);
        exp_t x;
        @(posedge clk);
        #1;
        en = 1'b1; flush = 1'b0; dv = v;
        rs = AW'(s); rt = AW'(t); dst = AW'(d); drw = w; dmr = m;
        #1;
        rst_n = 1'b0;
        hist.delete();
        m_fa = 0; m_fb = 0; m_cnt = 0;
        x.fa = 0; x.fb = 0; x.stall = 0; x.cnt = 0; x.tag = tag;
        sbq.push_back(x);
    endtask

    task automatic op(input string tag, input int s, input int t, input int d, input bit w, input bit m);
        step(tag, 1'b1, s, t, d, w, m, 1'b0, 1'b1);
    endtask

    task automatic nop(input string tag);
        step(tag, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: pop one expectation per cycle, sampled mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                n_cmp++;
                if (int'(fa) != e.fa) begin
                    n_bad++;
                    $display("FAIL %s fwd_a: got %0d expected %0d (t=%0t)", e.tag, fa, e.fa, $time);
                end
                n_cmp++;
                if (int'(fb) != e.fb) begin
                    n_bad++;
                    $display("FAIL %s fwd_b: got %0d expected %0d (t=%0t)", e.tag, fb, e.fb, $time);
                end
                n_cmp++;
                if (int'(stall) != e.stall) begin
                    n_bad++;
                    $display("FAIL %s stall: got %0d expected %0d (t=%0t)", e.tag, stall, e.stall, $time);
                end
                n_cmp++;
                if (int'(cnt) != e.cnt) begin
                    n_bad++;
                    $display("FAIL %s stall_count: got %0d expected %0d (t=%0t)", e.tag, cnt, e.cnt, $time);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int s, t, d;
        bit v, w, m, fl, e, hold;
        reset_step("reset", 1'b0, 0, 0, 0, 1'b0, 1'b0);

        // ALU chain: add $3,$1,$2 ; sub $4,$3,$5
        op("chain_add", 1, 2, 3, 1'b1, 1'b0);
        op("chain_sub", 3, 5, 4, 1'b1, 1'b0);
        nop("chain_chk");

        // Distance two, then both slots writing $3
        op("d2_add", 1, 2, 3, 1'b1, 1'b0);
        nop("d2_nop");
        op("d2_or", 7, 3, 6, 1'b1, 1'b0);
        op("prio_add1", 1, 2, 3, 1'b1, 1'b0);
        op("prio_add2", 1, 2, 3, 1'b1, 1'b0);
        op("prio_or", 7, 3, 6, 1'b1, 1'b0);
        nop("prio_chk");

        // Load-use: lw $2 ; add $4,$2,$2 (held in ID during the stall)
        op("lu_lw", 1, 0, 2, 1'b1, 1'b1);
        op("lu_add_stall", 2, 2, 4, 1'b1, 1'b0);
        op("lu_add_go", 2, 2, 4, 1'b1, 1'b0);
        nop("lu_chk");

        // Register zero never forwards or stalls
        op("z_add0", 1, 2, 0, 1'b1, 1'b0);
        op("z_use0", 0, 0, 5, 1'b1, 1'b0);
        op("z_lw0", 1, 0, 0, 1'b1, 1'b1);
        op("z_use_lw0", 0, 0, 5, 1'b1, 1'b0);
        nop("z_chk");

        // Flush wins over a load-use hazard
        op("fl_lw", 1, 0, 2, 1'b1, 1'b1);
        step("fl_add", 1'b1, 2, 2, 4, 1'b1, 1'b0, 1'b1, 1'b1);
        nop("fl_chk");
        nop("fl_chk2");

        // Freeze during a stall
        op("fz_lw", 1, 0, 2, 1'b1, 1'b1);
        step("fz_hold1", 1'b1, 2, 3, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        step("fz_hold2", 1'b1, 2, 3, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        op("fz_stall", 2, 3, 4, 1'b1, 1'b0);
        op("fz_go", 2, 3, 4, 1'b1, 1'b0);
        step("fz_sel_hold", 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        nop("fz_chk");

        // Reset while stalled, and reset while a hazard is presented
        op("rs_lw", 1, 0, 2, 1'b1, 1'b1);
        op("rs_stall", 2, 2, 4, 1'b1, 1'b0);
        reset_step("rs_mid_stall", 1'b1, 2, 2, 4, 1'b1, 1'b0);
        nop("rs_restart");
        op("rs_lw2", 1, 0, 2, 1'b1, 1'b1);
        reset_step("rs_mid_hazard", 1'b1, 2, 2, 4, 1'b1, 1'b0);
        op("rs_after", 2, 2, 4, 1'b1, 1'b0);
        nop("rs_chk");

        // Counter saturation: nine load-use stalls on a 3-bit counter
        for (int i = 0; i < 9; i++) begin
            op("sat_lw", 1, 0, 2, 1'b1, 1'b1);
            op("sat_stall", 2, 6, 4, 1'b1, 1'b0);
            op("sat_go", 2, 6, 4, 1'b1, 1'b0);
        end
        nop("sat_chk");

        // Random traffic over a small register range to force collisions
        reset_step("rnd_reset", 1'b0, 0, 0, 0, 1'b0, 1'b0);
        hold = 1'b0;
        v = 1'b0; s = 0; t = 0; d = 0; w = 1'b0; m = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (!hold) begin
                v = ($urandom_range(0, 9) != 0);
                s = $urandom_range(0, 3);
                t = $urandom_range(0, 3);
                d = $urandom_range(0, 3);
                w = ($urandom_range(0, 4) != 0);
                m = w && ($urandom_range(0, 2) == 0);
            end
            fl = ($urandom_range(0, 9) == 0);
            e  = ($urandom_range(0, 7) != 0);
            hold = model_stall(v, s, t, fl) || !e;
            step("rnd", v, s, t, d, w, m, fl, e);
        end
        nop("rnd_end");

        // Drain: monitor must empty the scoreboard within a few cycles
        for (int i = 0; i < 4 && sbq.size() > 0; i++) @(posedge clk);
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
